// File: rtl/fmps_readout_sequencer.sv
// FMPS readout sequencer: walks a snapshot of the packet-present bitmap, reads each present
// DPRAM entry and emits it as one AXI-stream beat. Optional payload checking: FMPS_SEQ_CHECK_EN.
module fmps_readout_sequencer #(
   parameter int          INDEX_WIDTH = 5,
   parameter logic [15:0] DATA_MAGIC  = 16'hCACA
) (
   input  logic                      sysClk,
   input  logic                      sysReset_n,
   input  logic                      startStrobe,
   input  logic                      clearStrobe,
   input  logic [2**INDEX_WIDTH-1:0] fmpsBitmap,
   output logic [INDEX_WIDTH-1:0]    fmpsReadoutAddress,
   input  logic [31:0]               fmpsReadout,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast,
   output logic [31:0]               m_tdata,
   output logic [INDEX_WIDTH-1:0]    m_tuser,
   output logic                      busy,
   output logic                      doneStrobe,
   output logic [15:0]               scanCount,
   output logic                      overrun,
   output logic [7:0]                overrunCount,
`ifdef FMPS_SEQ_CHECK_EN
   output logic [15:0]               errorCount,
   output logic                      checkErr,
`endif
   output logic [2:0]                fsmState
);

   localparam int DEPTH = 2**INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] ADDR_MAX = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SCAN    = 3'd1,
      SETTLE  = 3'd2,
      CAPTURE = 3'd3,
      HOLD    = 3'd4,
      DONE    = 3'd5
   } stateT;

   stateT                  state;
   stateT                  stateNext;
   logic [INDEX_WIDTH-1:0] addr;
   logic [DEPTH-1:0]       snap;
   logic [DEPTH-1:0]       upperBits;
   logic                   lastBeat;
   logic                   overrunEvent;

   // Stream handshake: a beat is transferred on a rising edge where m_tvalid and m_tready are
   // both high; while m_tvalid is high and m_tready low, m_tdata/m_tuser/m_tlast do not change.

   assign fmpsReadoutAddress = addr;
   assign busy               = (state != IDLE);
   assign doneStrobe         = (state == DONE);
   assign fsmState           = state;
   assign overrunEvent       = startStrobe && (state != IDLE);

   // The beat is last when no snapshot bit strictly above the current index is set.
   assign upperBits = (snap >> addr) >> 1;
   assign lastBeat  = ~|upperBits;

`ifdef FMPS_SEQ_CHECK_EN
   logic dataBad;
   assign dataBad  = fmpsReadout[31] | fmpsReadout[30] | fmpsReadout[29] |
                     (fmpsReadout[28:24] != 5'(addr)) |
                     (fmpsReadout[23:8] != DATA_MAGIC);
   assign checkErr = (state == CAPTURE) && dataBad;
`else
   localparam logic [15:0] unusedMagic = DATA_MAGIC;
`endif

   always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) state <= IDLE;
      else             state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (startStrobe) stateNext = SCAN;
         SCAN: begin
            if (snap[addr])            stateNext = SETTLE;
            else if (addr == ADDR_MAX) stateNext = DONE;
         end
         SETTLE:  stateNext = CAPTURE;
         CAPTURE: stateNext = HOLD;
         HOLD:    if (m_tready) stateNext = (addr == ADDR_MAX) ? DONE : SCAN;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
         addr     <= '0;
         snap     <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tdata  <= '0;
         m_tuser  <= '0;
      end else begin
         case (state)
            IDLE: if (startStrobe) begin
               snap <= fmpsBitmap;
               addr <= '0;
            end
            SCAN: if (!snap[addr] && addr != ADDR_MAX) addr <= addr + 1'b1;
            CAPTURE: begin
               m_tdata  <= fmpsReadout;
               m_tuser  <= addr;
               m_tlast  <= lastBeat;
               m_tvalid <= 1'b1;
            end
            HOLD: if (m_tready) begin
               m_tvalid <= 1'b0;
               if (addr != ADDR_MAX) addr <= addr + 1'b1;
            end
            DONE:    addr <= '0;
            default: ;
         endcase
      end
   end

   // A clear coinciding with a new event leaves that event counted once.
   always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
         scanCount    <= '0;
         overrun      <= 1'b0;
         overrunCount <= '0;
`ifdef FMPS_SEQ_CHECK_EN
         errorCount   <= '0;
`endif
      end else if (clearStrobe) begin
         scanCount    <= '0;
         overrun      <= overrunEvent;
         overrunCount <= overrunEvent ? 8'd1 : 8'd0;
`ifdef FMPS_SEQ_CHECK_EN
         errorCount   <= checkErr ? 16'd1 : 16'd0;
`endif
      end else begin
         if (state == DONE) scanCount <= scanCount + 16'd1;
         if (overrunEvent) begin
            overrun <= 1'b1;
            if (overrunCount != 8'hFF) overrunCount <= overrunCount + 8'd1;
         end
`ifdef FMPS_SEQ_CHECK_EN
         if (checkErr && errorCount != 16'hFFFF) errorCount <= errorCount + 16'd1;
`endif
      end
   end

endmodule

// File: tb/tb_fmps_readout_sequencer.sv
// Directed bench for fmps_readout_sequencer with a beat scoreboard; define FMPS_SEQ_CHECK_EN
// to also exercise payload checking.
module tb_fmps_readout_sequencer;

   localparam int IW    = 5;
   localparam int DEPTH = 32;
   localparam int BW    = 1 + IW + 32;

   logic             sysClk;
   logic             sysReset_n;
   logic             startStrobe;
   logic             clearStrobe;
   logic [DEPTH-1:0] fmpsBitmap;
   logic [IW-1:0]    fmpsReadoutAddress;
   logic [31:0]      fmpsReadout;
   logic             m_tvalid;
   logic             m_tready;
   logic             m_tlast;
   logic [31:0]      m_tdata;
   logic [IW-1:0]    m_tuser;
   logic             busy;
   logic             doneStrobe;
   logic [15:0]      scanCount;
   logic             overrun;
   logic [7:0]       overrunCount;
   logic [2:0]       fsmState;
`ifdef FMPS_SEQ_CHECK_EN
   logic [15:0]      errorCount;
   logic             checkErr;
   int               errPulses = 0;
`endif

   logic [31:0]   mem [DEPTH];
   logic [BW-1:0] exp_q[$];
   int            checks    = 0;
   int            errors    = 0;
   int            beatCount = 0;
   int            readyMode = 0;

   fmps_readout_sequencer #(.INDEX_WIDTH(IW), .DATA_MAGIC(16'hCACA)) dut (
      .sysClk             (sysClk),
      .sysReset_n         (sysReset_n),
      .startStrobe        (startStrobe),
      .clearStrobe        (clearStrobe),
      .fmpsBitmap         (fmpsBitmap),
      .fmpsReadoutAddress (fmpsReadoutAddress),
      .fmpsReadout        (fmpsReadout),
      .m_tvalid           (m_tvalid),
      .m_tready           (m_tready),
      .m_tlast            (m_tlast),
      .m_tdata            (m_tdata),
      .m_tuser            (m_tuser),
      .busy               (busy),
      .doneStrobe         (doneStrobe),
      .scanCount          (scanCount),
      .overrun            (overrun),
      .overrunCount       (overrunCount),
`ifdef FMPS_SEQ_CHECK_EN
      .errorCount         (errorCount),
      .checkErr           (checkErr),
`endif
      .fsmState           (fsmState)
   );

   // Clock and DPRAM model (synchronous read, one cycle latency)
   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   always @(posedge sysClk) fmpsReadout <= mem[fmpsReadoutAddress];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysClk);
      #1;
   endtask

   task automatic pushBeat(input int idx, input logic last);
      exp_q.push_back({last, IW'(idx), mem[idx]});
   endtask

   task automatic startScan();
      beatCount   = 0;
      startStrobe = 1'b1;
      tick();
      startStrobe = 1'b0;
   endtask

   task automatic waitDone(output int n);
      n = 0;
      while (!doneStrobe && n < 400) begin
         tick();
         n++;
      end
      check("done_seen", doneStrobe, 1);
   endtask

   // Sink ready driver: 0 = always ready, 1 = toggling, 2 = stalled
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge sysClk);
         #1;
         case (readyMode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Monitor: every valid cycle must present the head of the expected queue
   always @(negedge sysClk) begin
      if (sysReset_n && m_tvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected no beat", {m_tlast, m_tuser, m_tdata});
         end else begin
            check("beat", {m_tlast, m_tuser, m_tdata}, exp_q[0]);
            if (m_tready) begin
               void'(exp_q.pop_front());
               beatCount++;
            end
         end
      end
   end

`ifdef FMPS_SEQ_CHECK_EN
   always @(negedge sysClk) begin
      if (sysReset_n && checkErr) begin
         errPulses++;
         check("checkErr_in_capture", fsmState, 3);
      end
   end
`endif

   initial begin
      int n;
      sysReset_n  = 1'b0;
      startStrobe = 1'b0;
      clearStrobe = 1'b0;
      fmpsBitmap  = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = {3'b000, 5'(i), 16'hCACA, 8'(i * 7)};

      repeat (3) tick();
      check("rst_tvalid", m_tvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", doneStrobe, 0);
      check("rst_addr", fmpsReadoutAddress, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tuser_tlast", {m_tuser, m_tlast}, 0);
      check("rst_counters", {scanCount, overrun, overrunCount}, 0);
      check("rst_state", fsmState, 0);
      sysReset_n = 1'b1;
      tick();

      // Single entry at index 0, latency to doneStrobe
      readyMode  = 0;
      mem[0]     = 32'h00CA_CA00;
      fmpsBitmap = 32'h0000_0001;
      pushBeat(0, 1'b1);
      startScan();
      waitDone(n);
      check("single_done_latency", n, 35);
      tick();
      check("single_beats", beatCount, 1);
      check("single_scanCount", scanCount, 1);
      check("single_idle", busy, 0);

      // Sixteen entries with a stalling sink; bitmap changes mid-scan are ignored
      readyMode  = 1;
      fmpsBitmap = 32'h0000_FFFF;
      for (int i = 0; i < 16; i++) pushBeat(i, i == 15);
      startScan();
      fmpsBitmap = 32'hFFFF_0000;
      waitDone(n);
      tick();
      check("sixteen_beats", beatCount, 16);
      check("sixteen_queue", exp_q.size(), 0);
      check("sixteen_scanCount", scanCount, 2);

      // Empty bitmap: full traversal, no beats
      readyMode  = 0;
      fmpsBitmap = '0;
      startScan();
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      check("empty_busy_cycles", n, 33);
      check("empty_beats", beatCount, 0);
      check("empty_scanCount", scanCount, 3);

      // Overrun: two starts during a scan
      fmpsBitmap = 32'h0000_0005;
      pushBeat(0, 1'b0);
      pushBeat(2, 1'b1);
      startScan();
      repeat (3) tick();
      startStrobe = 1'b1;
      tick();
      startStrobe = 1'b0;
      repeat (4) tick();
      startStrobe = 1'b1;
      tick();
      startStrobe = 1'b0;
      waitDone(n);
      tick();
      check("ovr_count", overrunCount, 2);
      check("ovr_flag", overrun, 1);
      check("ovr_scanCount", scanCount, 4);
      check("ovr_beats", beatCount, 2);
      repeat (3) tick();
      check("ovr_no_extra_scan", busy, 0);

      // Clear coinciding with an overrun event
      fmpsBitmap = '0;
      startScan();
      repeat (2) tick();
      startStrobe = 1'b1;
      clearStrobe = 1'b1;
      tick();
      startStrobe = 1'b0;
      clearStrobe = 1'b0;
      check("clrset_ovrCount", overrunCount, 1);
      check("clrset_ovr", overrun, 1);
      check("clrset_scanCount", scanCount, 0);
      waitDone(n);
      tick();
      check("clrset_scan_after", scanCount, 1);

      // Saturating overrun count
      startStrobe = 1'b1;
      repeat (300) tick();
      startStrobe = 1'b0;
      check("ovr_saturate", overrunCount, 255);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      clearStrobe = 1'b1;
      tick();
      clearStrobe = 1'b0;
      check("clear_all", {scanCount, overrun, overrunCount}, 0);

      // Reset while a beat is held
      readyMode  = 2;
      fmpsBitmap = 32'h0000_0008;
      pushBeat(3, 1'b1);
      startScan();
      n = 0;
      while (!m_tvalid && n < 50) begin
         tick();
         n++;
      end
      check("hold_reached", {m_tvalid, fsmState}, {1'b1, 3'd4});
      repeat (2) tick();
      #2;
      sysReset_n = 1'b0;
      #1;
      check("rst_hold_tvalid", m_tvalid, 0);
      check("rst_hold_busy_addr", {busy, fmpsReadoutAddress}, 0);
      exp_q.delete();
      tick();
      sysReset_n = 1'b1;
      readyMode  = 0;
      tick();
      check("rst_hold_scanCount", scanCount, 0);
      pushBeat(3, 1'b1);
      startScan();
      check("rescan_from_zero", {fsmState, fmpsReadoutAddress}, {3'd1, 5'd0});
      waitDone(n);
      tick();
      check("rescan_beats", beatCount, 1);
      check("rescan_scanCount", scanCount, 1);

`ifdef FMPS_SEQ_CHECK_EN
      // Bad index field at entry 3: flagged but still emitted
      mem[3]     = {3'b000, 5'd4, 16'hCACA, 8'h33};
      fmpsBitmap = 32'h0000_0008;
      errPulses  = 0;
      pushBeat(3, 1'b1);
      startScan();
      waitDone(n);
      tick();
      check("chk_errorCount", errorCount, 1);
      check("chk_pulses", errPulses, 1);
      check("chk_beats", beatCount, 1);
`endif

      repeat (3) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
